mac_product_accumulator: RTL and testbench

Downstream consumer of the team's combinational 3x4 array multiplier: takes its 7-bit unsigned product, one per handshake, and sums a fixed-length frame of `LEN` products into an accumulator. When the frame completes, it presents the sum on a valid/ready output and holds it until taken. It then clears itself and starts the next frame. It is the registered stage that turns the multiplier into a multiply-accumulate datapath.

---
 rtl/mac_acc_pkg.sv | 12 +
 rtl/mac_acc_counter.sv | 30 +++
 rtl/mac_product_accumulator.sv | 95 +++++++++
 tb/tb_mac_product_accumulator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pkg.sv
// Shared types and constants for the multiply-accumulate product accumulator.
package mac_acc_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int unsigned PROD_W   = 7;
   localparam int unsigned PROD_MAX = 105;

endpackage

// File: rtl/mac_acc_counter.sv
// Frame counter: counts accepted products and flags the final product of a frame.
module mac_acc_counter
#(
   parameter int unsigned LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clear,
   output logic last
);
   import mac_acc_pkg::*;

   localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

   logic [7:0] cnt;

   assign last = (cnt == LAST_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= last ? '0 : cnt + 8'd1;
      end
   end

endmodule

// File: rtl/mac_product_accumulator.sv
// Sums LEN multiplier products per frame and presents the sum on a valid/ready port.
// Build option MAC_ACC_SAT_EN: saturate the accumulator on carry-out instead of wrapping.
module mac_product_accumulator
#(
   parameter int unsigned PROD_W = 7,
   parameter int unsigned ACC_W  = 10,
   parameter int unsigned LEN    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);
   import mac_acc_pkg::state_t;
   import mac_acc_pkg::ACC;
   import mac_acc_pkg::HOLD;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic             ovf_nxt;
   logic             accept;
   logic             last;
   logic [ACC_W:0]   add;

   // Handshake outputs depend on state only, so there is no input-to-output path.
   assign in_ready  = (state == ACC);
   assign out_valid = (state == HOLD);
   assign sum       = acc;
   assign accept    = in_valid & in_ready;
   assign add       = {1'b0, acc} + (ACC_W+1)'(prod);

   mac_acc_counter #(
      .LEN (LEN)
   ) u_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (accept),
      .clear (clr),
      .last  (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACC;
         acc   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      ovf_nxt   = ovf;
      if (clr) begin
         state_nxt = ACC;
         acc_nxt   = '0;
         ovf_nxt   = 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (accept) begin
                  ovf_nxt = ovf | add[ACC_W];
`ifdef MAC_ACC_SAT_EN
                  acc_nxt = add[ACC_W] ? '1 : add[ACC_W-1:0];
`else
                  acc_nxt = add[ACC_W-1:0];
`endif
                  if (last) begin
                     state_nxt = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_nxt = ACC;
                  acc_nxt   = '0;
                  ovf_nxt   = 1'b0;
               end
            end
            default: state_nxt = ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_product_accumulator.sv
// Self-checking bench: directed steps with random products against an arithmetic frame-sum model.
module tb_mac_product_accumulator;

   localparam int ACC_W = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // main instance: default parameters
   logic             clr, in_valid, in_ready, out_valid, out_ready, ovf;
   logic [6:0]       prod;
   logic [ACC_W-1:0] sum;
   // narrow instance: ACC_W=8, LEN=3
   logic             clr_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, ovf_b;
   logic [6:0]       prod_b;
   logic [7:0]       sum_b;
   // single-product frame instance: LEN=1
   logic             clr_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c, ovf_c;
   logic [6:0]       prod_c;
   logic [9:0]       sum_c;

   mac_product_accumulator dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf)
   );

   mac_product_accumulator #(.ACC_W(8), .LEN(3)) dut_b (
      .clk(clk), .rst(rst), .clr(clr_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .prod(prod_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .sum(sum_b), .ovf(ovf_b)
   );

   mac_product_accumulator #(.LEN(1)) dut_c (
      .clk(clk), .rst(rst), .clr(clr_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
      .prod(prod_c), .out_valid(out_valid_c), .out_ready(out_ready_c), .sum(sum_c), .ovf(ovf_c)
   );

   int checks = 0;
   int errors = 0;
   int frame_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Frame sum of a given total: wraps mod 2^w, or pins at all-ones when saturating.
   function automatic void model(input longint total, input int w, output int s, output bit o);
      longint lim;
      lim = longint'(1) << w;
      o = (total >= lim);
`ifdef MAC_ACC_SAT_EN
      s = o ? int'(lim - 1) : int'(total);
`else
      s = int'(total % lim);
`endif
   endfunction

   function automatic longint q_total();
      longint t = 0;
      foreach (frame_q[i]) t += frame_q[i];
      return t;
   endfunction

   // Offers every product in frame_q with optional random gaps, checking the running sum.
   task automatic send_items(input int gap_max);
      int     idx = 0;
      longint run = 0;
      int     es;
      bit     eo;
      while (idx < frame_q.size()) begin
         @(negedge clk);
         model(run, ACC_W, es, eo);
         check("partial_sum", 32'(sum), 32'(es));
         check("in_ready_acc", 32'(in_ready), 32'd1);
         check("out_valid_acc", 32'(out_valid), 32'd0);
         if (gap_max == 0 || $urandom_range(0, gap_max) != 0) begin
            in_valid = 1'b1;
            prod     = 7'(frame_q[idx]);
            run     += frame_q[idx];
            idx++;
         end else begin
            in_valid = 1'b0;
            prod     = 7'($urandom_range(0, 105));
         end
      end
   endtask

   task automatic finish_frame();
      int es;
      bit eo;
      @(negedge clk);
      in_valid = 1'b0;
      model(q_total(), ACC_W, es, eo);
      check("done_out_valid", 32'(out_valid), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_sum", 32'(sum), 32'(es));
      check("done_ovf", 32'(ovf), 32'(eo));
   endtask

   task automatic release_sum();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("rel_out_valid", 32'(out_valid), 32'd0);
      check("rel_in_ready", 32'(in_ready), 32'd1);
      check("rel_sum", 32'(sum), 32'd0);
      check("rel_ovf", 32'(ovf), 32'd0);
   endtask

   task automatic fill_const(input int n, input int v);
      frame_q = {};
      for (int i = 0; i < n; i++) frame_q.push_back(v);
   endtask

   task automatic fill_rand(input int n);
      frame_q = {};
      for (int i = 0; i < n; i++) frame_q.push_back(int'($urandom_range(0, 105)));
   endtask

   initial begin
      int es;
      bit eo;
      clr = 0; in_valid = 0; prod = '0; out_ready = 0;
      clr_b = 0; in_valid_b = 0; prod_b = '0; out_ready_b = 0;
      clr_c = 0; in_valid_c = 0; prod_c = '0; out_ready_c = 0;

      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 8 x 105 with out_ready high: exactly one bubble before the next frame
      out_ready = 1'b1;
      fill_const(8, 105);
      send_items(0);
      finish_frame();
      release_sum();

      // 1..8, held for 5 cycles while a product is offered
      out_ready = 1'b0;
      frame_q = {};
      for (int i = 1; i <= 8; i++) frame_q.push_back(i);
      send_items(0);
      finish_frame();
      in_valid = 1'b1;
      prod     = 7'd99;
      repeat (5) begin
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_sum", 32'(sum), 32'd36);
      end
      release_sum();

      // gapped input streams
      fill_const(8, 10);
      send_items(3);
      finish_frame();
      check("gap_sum80", 32'(sum), 32'd80);
      release_sum();
      for (int f = 0; f < 4; f++) begin
         out_ready = 1'b0;
         fill_rand(8);
         send_items(f);
         finish_frame();
         release_sum();
      end

      // clr after 4 products, with a product offered in the same cycle
      out_ready = 1'b0;
      fill_const(4, 50);
      send_items(0);
      @(negedge clk);
      check("pre_clr_sum", 32'(sum), 32'd200);
      clr = 1'b1; in_valid = 1'b1; prod = 7'd50;
      @(negedge clk);
      check("clr_sum", 32'(sum), 32'd0);
      check("clr_in_ready", 32'(in_ready), 32'd1);
      check("clr_out_valid", 32'(out_valid), 32'd0);
      clr = 1'b0; in_valid = 1'b0;
      fill_const(8, 2);
      send_items(0);
      finish_frame();
      check("post_clr_sum16", 32'(sum), 32'd16);
      // clr while holding
      clr = 1'b1;
      @(negedge clk);
      check("clr_hold_out_valid", 32'(out_valid), 32'd0);
      check("clr_hold_sum", 32'(sum), 32'd0);
      clr = 1'b0;

      // narrow accumulator: 3 x 105 overflows 8 bits
      in_valid_b = 1'b1; prod_b = 7'd105;
      @(negedge clk);
      check("b_sum1", 32'(sum_b), 32'd105);
      @(negedge clk);
      check("b_sum2", 32'(sum_b), 32'd210);
      check("b_ovf2", 32'(ovf_b), 32'd0);
      @(negedge clk);
      in_valid_b = 1'b0;
      model(315, 8, es, eo);
      check("b_done_valid", 32'(out_valid_b), 32'd1);
      check("b_done_sum", 32'(sum_b), 32'(es));
      check("b_done_ovf", 32'(ovf_b), 32'(eo));
      out_ready_b = 1'b1;
      @(negedge clk);
      check("b_rel_sum", 32'(sum_b), 32'd0);
      check("b_rel_ovf", 32'(ovf_b), 32'd0);
      out_ready_b = 1'b0;

      // LEN=1: every product completes a frame
      in_valid_c = 1'b1; prod_c = 7'd77;
      @(negedge clk);
      in_valid_c = 1'b0;
      check("c_valid", 32'(out_valid_c), 32'd1);
      check("c_sum", 32'(sum_c), 32'd77);
      check("c_in_ready", 32'(in_ready_c), 32'd0);
      out_ready_c = 1'b1; in_valid_c = 1'b1; prod_c = 7'd5;
      @(negedge clk);
      check("c_rel_valid", 32'(out_valid_c), 32'd0);
      @(negedge clk);
      check("c_second_sum", 32'(sum_c), 32'd5);
      check("c_second_valid", 32'(out_valid_c), 32'd1);
      in_valid_c = 1'b0;

      // asynchronous reset while both main and narrow instances hold a sum
      in_valid_b = 1'b1; prod_b = 7'd105;
      repeat (3) @(negedge clk);
      in_valid_b = 1'b0;
      out_ready = 1'b0;
      fill_const(8, 105);
      send_items(0);
      finish_frame();
      check("b_pre_rst_ovf", 32'(ovf_b), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_sum", 32'(sum), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_b_out_valid", 32'(out_valid_b), 32'd0);
      check("arst_b_sum", 32'(sum_b), 32'd0);
      check("arst_b_ovf", 32'(ovf_b), 32'd0);
      check("arst_b_in_ready", 32'(in_ready_b), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      fill_rand(8);
      send_items(1);
      finish_frame();
      release_sum();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
